// File: rtl/qsn_left_pipe.sv
// Pipelined cyclic left-rotation network: one register stage per shift bit, global-stall handshake.
// Optional out-of-range shift flag built when QSN_LEFT_SHIFT_CHK_EN is defined.
module qsn_left_pipe #(
    parameter int LEN   = 3,
    parameter int MSG_W = 4,
    localparam int SEL_W = $clog2(LEN)
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LEN*MSG_W-1:0]   in_msg,
    input  logic [SEL_W-1:0]       in_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LEN*MSG_W-1:0]   out_msg,
    output logic                   out_shift_err
);

    typedef logic [LEN*MSG_W-1:0] vec_t;

    logic             advance;
    vec_t             msg_q     [SEL_W];
    vec_t             msg_d     [SEL_W];
    vec_t             src_msg   [SEL_W];
    logic [SEL_W-1:0] shift_q   [SEL_W];
    logic [SEL_W-1:0] shift_d   [SEL_W];
    logic [SEL_W-1:0] src_shift [SEL_W];
    logic [SEL_W-1:0] valid_q, valid_d, src_valid;

    // Lane i moves to lane (i + r) mod LEN.
    function automatic vec_t rotl(input vec_t v, input int unsigned r);
        vec_t o;
        o = '0;
        for (int unsigned i = 0; i < LEN; i++) begin
            o[((i + r) % LEN) * MSG_W +: MSG_W] = v[i * MSG_W +: MSG_W];
        end
        return o;
    endfunction

    always_comb begin
        advance      = !valid_q[SEL_W-1] || out_ready;
        src_msg[0]   = in_msg;
        src_shift[0] = in_shift;
        src_valid[0] = in_valid;
        for (int unsigned k = 1; k < SEL_W; k++) begin
            src_msg[k]   = msg_q[k-1];
            src_shift[k] = shift_q[k-1];
            src_valid[k] = valid_q[k-1];
        end
        for (int unsigned k = 0; k < SEL_W; k++) begin
            msg_d[k]   = msg_q[k];
            shift_d[k] = shift_q[k];
            valid_d[k] = valid_q[k];
            if (advance) begin
                msg_d[k]   = src_shift[k][k] ? rotl(src_msg[k], (32'd1 << k) % LEN) : src_msg[k];
                shift_d[k] = src_shift[k];
                valid_d[k] = src_valid[k];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < SEL_W; k++) begin
                msg_q[k]   <= '0;
                shift_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int unsigned k = 0; k < SEL_W; k++) begin
                msg_q[k]   <= msg_d[k];
                shift_q[k] <= shift_d[k];
            end
            valid_q <= valid_d;
        end
    end

`ifdef QSN_LEFT_SHIFT_CHK_EN
    logic [SEL_W-1:0] err_q, err_d, src_err;

    always_comb begin
        src_err[0] = 32'(in_shift) >= 32'(LEN);
        for (int unsigned k = 1; k < SEL_W; k++) begin
            src_err[k] = err_q[k-1];
        end
        err_d = advance ? src_err : err_q;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_shift_err = err_q[SEL_W-1];
`else
    assign out_shift_err = 1'b0;
`endif

    assign in_ready  = advance;
    assign out_valid = valid_q[SEL_W-1];
    assign out_msg   = msg_q[SEL_W-1];

endmodule

// File: tb/tb_qsn_left_pipe.sv
// Self-checking bench for qsn_left_pipe (LEN=3, MSG_W=4): directed scenarios plus
// randomized traffic against a direct modular-rotation reference and FIFO scoreboard.
module tb_qsn_left_pipe;

    localparam int LEN   = 3;
    localparam int MSG_W = 4;
    localparam int SEL_W = 2;
    localparam int VW    = LEN * MSG_W;
`ifdef QSN_LEFT_SHIFT_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          sys_clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, out_shift_err;
    logic [VW-1:0] in_msg, out_msg;
    logic [SEL_W-1:0] in_shift;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [VW-1:0] msg;
        logic          err;
    } item_t;

    always #5 sys_clk = ~sys_clk;

    qsn_left_pipe #(.LEN(LEN), .MSG_W(MSG_W)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_msg       (in_msg),
        .in_shift     (in_shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_msg      (out_msg),
        .out_shift_err(out_shift_err)
    );

    // Reference: output lane (i + s) mod LEN takes input lane i.
    function automatic logic [VW-1:0] ref_rot(input logic [VW-1:0] v, input int s);
        logic [MSG_W-1:0] lanes [LEN];
        logic [VW-1:0]    r;
        for (int i = 0; i < LEN; i++) lanes[(i + s) % LEN] = v[i*MSG_W +: MSG_W];
        for (int i = 0; i < LEN; i++) r[i*MSG_W +: MSG_W] = lanes[i];
        return r;
    endfunction

    function automatic logic ref_err(input int s);
        return CHK && (s >= LEN);
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_msg = '0; in_shift = '0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_msg !== '0) $display("FAIL reset_msg got %h exp 000", out_msg); else n_pass++;
        n_checks++; if (out_shift_err !== 1'b0) $display("FAIL reset_err got %b exp 0", out_shift_err); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        // Item offered while reset is held must be ignored.
        in_valid = 1'b1; in_msg = 12'h5A3; in_shift = 2'd1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_no_accept got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_shift_sweep();
        logic [VW-1:0] exp_tab [3];
        exp_tab[0] = 12'hCBA; exp_tab[1] = 12'hBAC; exp_tab[2] = 12'hACB;
        out_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid = 1'b1; in_msg = 12'hCBA; in_shift = SEL_W'(s);
            #1;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL sweep_in_ready s=%0d got %b exp 1", s, in_ready); else n_pass++;
            tick();
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b0) $display("FAIL sweep_early s=%0d got %b exp 0", s, out_valid); else n_pass++;
            tick();
            n_checks++; if (out_valid !== 1'b1) $display("FAIL sweep_valid s=%0d got %b exp 1", s, out_valid); else n_pass++;
            n_checks++; if (out_msg !== exp_tab[s]) $display("FAIL sweep_msg s=%0d got %h exp %h", s, out_msg, exp_tab[s]); else n_pass++;
            n_checks++; if (out_shift_err !== 1'b0) $display("FAIL sweep_err s=%0d got %b exp 0", s, out_shift_err); else n_pass++;
            tick();
            n_checks++; if (out_valid !== 1'b0) $display("FAIL sweep_gone s=%0d got %b exp 0", s, out_valid); else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        out_ready = 1'b1;
        in_valid = 1'b1; in_msg = 12'hCBA; in_shift = 2'd3;
        tick();
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL oor_valid got %b exp 1", out_valid); else n_pass++;
        n_checks++; if (out_msg !== 12'hCBA) $display("FAIL oor_msg got %h exp cba", out_msg); else n_pass++;
        n_checks++; if (out_shift_err !== CHK) $display("FAIL oor_err got %b exp %b", out_shift_err, CHK); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] exp_tab [4];
        int            sh [4];
        exp_tab[0] = 12'hCBA; exp_tab[1] = 12'hBAC; exp_tab[2] = 12'hACB; exp_tab[3] = 12'hBAC;
        sh[0] = 0; sh[1] = 1; sh[2] = 2; sh[3] = 1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 4);
            in_msg   = 12'hCBA;
            in_shift = SEL_W'(sh[c % 4]);
            #1;
            if (c < 4) begin
                n_checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready c=%0d got %b exp 1", c, in_ready); else n_pass++;
            end
            tick();
            if (c >= 1 && c <= 4) begin
                n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid c=%0d got %b exp 1", c, out_valid); else n_pass++;
                n_checks++; if (out_msg !== exp_tab[c-1]) $display("FAIL b2b_msg c=%0d got %h exp %h", c, out_msg, exp_tab[c-1]); else n_pass++;
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] m   [3];
        int            s   [3];
        logic [VW-1:0] exp [3];
        for (int i = 0; i < 3; i++) begin
            m[i] = VW'($urandom); s[i] = $urandom_range(0, 2); exp[i] = ref_rot(m[i], s[i]);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_msg = m[0]; in_shift = SEL_W'(s[0]); tick();
        in_msg = m[1]; in_shift = SEL_W'(s[1]); tick();
        in_msg = m[2]; in_shift = SEL_W'(s[2]); out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_comb got %b exp 0", in_ready); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready c=%0d got %b exp 0", c, in_ready); else n_pass++;
            n_checks++; if (out_valid !== 1'b1 || out_msg !== exp[0])
                $display("FAIL bp_hold c=%0d got %b/%h exp 1/%h", c, out_valid, out_msg, exp[0]); else n_pass++;
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release got %b exp 1", in_ready); else n_pass++;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_msg !== exp[i])
                $display("FAIL bp_drain i=%0d got %b/%h exp 1/%h", i, out_valid, out_msg, exp[i]); else n_pass++;
            tick();
        end
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b exp 0", out_valid); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        logic [VW-1:0] nm;
        out_ready = 1'b1;
        in_valid = 1'b1; in_msg = 12'h123; in_shift = 2'd1; tick();
        in_msg = 12'h456; in_shift = 2'd2; tick();
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_valid got %b exp 0", out_valid); else n_pass++;
        n_checks++; if (out_msg !== '0) $display("FAIL rmid_msg got %h exp 000", out_msg); else n_pass++;
        n_checks++; if (out_shift_err !== 1'b0) $display("FAIL rmid_err got %b exp 0", out_shift_err); else n_pass++;
        rst = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_ghost c=%0d got %b exp 0", c, out_valid); else n_pass++;
        end
        nm = VW'($urandom);
        in_valid = 1'b1; in_msg = nm; in_shift = 2'd2; tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmid_lat_early got %b exp 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_msg !== ref_rot(nm, 2))
            $display("FAIL rmid_lat got %b/%h exp 1/%h", out_valid, out_msg, ref_rot(nm, 2)); else n_pass++;
        tick();
    endtask

    task automatic test_bubbles();
        logic          pat [5];
        logic [VW-1:0] m   [5];
        int            s   [5];
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            m[c] = VW'($urandom); s[c] = $urandom_range(0, 2);
            in_valid = pat[c]; in_msg = m[c]; in_shift = SEL_W'(s[c]);
            tick();
            if (c >= 1) begin
                n_checks++; if (out_valid !== pat[c-1]) $display("FAIL bub_valid c=%0d got %b exp %b", c, out_valid, pat[c-1]); else n_pass++;
                if (pat[c-1]) begin
                    n_checks++; if (out_msg !== ref_rot(m[c-1], s[c-1]))
                        $display("FAIL bub_msg c=%0d got %h exp %h", c, out_msg, ref_rot(m[c-1], s[c-1])); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_random();
        item_t q [$];
        item_t it;
        int    s;
        rst = 1'b1; in_valid = 1'b0; tick(); rst = 1'b0;
        for (int c = 0; c < 400; c++) begin
            s = $urandom_range(0, 3);
            in_valid = $urandom_range(0, 1); in_msg = VW'($urandom); in_shift = SEL_W'(s);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++; if (in_ready !== (!out_valid || out_ready))
                $display("FAIL rnd_in_ready c=%0d got %b exp %b", c, in_ready, !out_valid || out_ready); else n_pass++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++; $display("FAIL rnd_extra c=%0d got %h exp none", c, out_msg);
                end else begin
                    it = q.pop_front();
                    n_checks++; if (out_msg !== it.msg || out_shift_err !== it.err)
                        $display("FAIL rnd_item c=%0d got %h/%b exp %h/%b", c, out_msg, out_shift_err, it.msg, it.err); else n_pass++;
                end
            end
            if (in_valid && in_ready) q.push_back('{msg: ref_rot(in_msg, s), err: ref_err(s)});
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                it = q.pop_front();
                n_checks++; if (out_msg !== it.msg || out_shift_err !== it.err)
                    $display("FAIL rnd_drain c=%0d got %h/%b exp %h/%b", c, out_msg, out_shift_err, it.msg, it.err); else n_pass++;
            end
            tick();
        end
        n_checks++; if (q.size() != 0) $display("FAIL rnd_lost got %0d pending exp 0", q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_shift_sweep();
        test_out_of_range();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_bubbles();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qsn_left_pipe.md
# qsn_left_pipe

Pipelined cyclic left-rotation network for the partial message-passing datapath. It is the inverse-direction counterpart of the right-shift QSN: it takes a row of LEN lane messages that were rotated right by the QSN, rotates them left by the same shift value, and restores the original lane order before write-back to the column memories. It uses one register stage per shift bit and a valid/ready handshake on both sides, so it can stall behind the memory-share arbiter.

## Interface
- LEN, 3, number of lanes (message vector length); legal range ≥ 2.
- MSG_W, 4, bit width of one lane message.
- SEL_W (localparam), $clog2(LEN), width of the shift value and the number of pipeline stages.
- sys_clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  input item present.
- in_ready  output  1  block accepts the item this cycle.
- in_msg  input  LEN*MSG_W  lane i occupies bits [i*MSG_W +: MSG_W].
- in_shift  input  SEL_W  left-rotation amount, nominally 0..LEN-1.
- out_valid  output  1  output item present.
- out_ready  input  1  downstream accepts the item.
- out_msg  output  LEN*MSG_W  rotated vector; same lane packing as in_msg.
- out_shift_err  output  1  in_shift of the current output item was ≥ LEN (configurable).

## Operation
- Function: out lane ((i + s) mod LEN) = in lane i, where s = in_shift. This is a cyclic left rotation toward the MSB lane.
- Structure: stage k (k = 0..SEL_W-1) rotates left by (2^k mod LEN) when bit k of the carried shift is 1, and passes the vector through otherwise. Each stage registers msg, the remaining shift bits, err and valid.
- Out-of-range shift (s ≥ LEN): the stages compose to a rotation by s mod LEN. The result is still produced, with no drop and no stall. out_shift_err is set alongside the item.
- Flow control is a global-stall pipeline.
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - All stages shift together when advance = 1 and hold when advance = 0.
- Bubbles (stages with valid = 0) propagate as items do. They are not collapsed.
- An input is accepted on a rising edge when in_valid && in_ready. An output is consumed on a rising edge when out_valid && out_ready.
- in_msg and in_shift are sampled only on acceptance. Values on those inputs in other cycles have no effect.
- Items leave in acceptance order, with no loss or duplication.

## Timing
- Reset: when rst = 1 at a rising edge, on that edge:
  - all stage valid bits go to 0, so out_valid = 0;
  - out_msg = 0 and out_shift_err = 0;
  - all internal data registers go to 0.
- While rst is held high, in_ready = 1 (advance = 1), but nothing is accepted.
- Reset mid-operation discards all in-flight items. The first accepted item after reset appears SEL_W cycles later.
- Latency: an item accepted at edge t is presented with out_valid = 1 after edge t + SEL_W − 1 when there is no stall. For LEN = 3 this is 2 cycles: accept at edge 0, present after edge 1.
- Throughput is one item per cycle when out_ready is held at 1.
- Stall: while out_valid && !out_ready:
  - in_ready = 0 in the same cycle (combinational from out_ready);
  - all stage contents, out_msg and out_shift_err are held stable.
- Simultaneous accept and consume in one cycle is allowed and keeps the pipeline full.
- out_msg and out_shift_err are registered. in_ready is the only combinational output path.

## Configuration
- QSN_LEFT_SHIFT_CHK_EN defined:
  - a comparator flags in_shift ≥ LEN at acceptance;
  - the flag travels with the item and drives out_shift_err.
- QSN_LEFT_SHIFT_CHK_EN undefined:
  - no comparator or err registers are built;
  - out_shift_err is tied to 0;
  - rotation behaviour is identical (mod LEN).

## Test plan
All scenarios use LEN = 3, MSG_W = 4, and in_msg = 0xCBA (lane2 = C, lane1 = B, lane0 = A).
- Shift sweep with out_ready = 1:
  - s = 0 gives out_msg 0xCBA;
  - s = 1 gives 0xBAC;
  - s = 2 gives 0xACB;
  - each result appears 2 cycles after acceptance, with out_shift_err = 0.
- Out-of-range, with the macro defined: s = 3 gives out_msg 0xCBA and out_shift_err = 1. Without the macro: out_msg 0xCBA and out_shift_err = 0.
- Back-to-back: 4 consecutive items with s = 0, 1, 2, 1 and out_ready = 1 produce 0xCBA, 0xBAC, 0xACB, 0xBAC on 4 consecutive cycles, with in_ready held at 1.
- Backpressure:
  - drop out_ready for 3 cycles while 3 items are in flight: in_ready = 0 and out_msg holds stable throughout;
  - after release, the items drain in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 2 items in flight. Then out_valid = 0, out_msg = 0 and out_shift_err = 0, and neither flushed item ever appears.
- Bubble handling: in_valid toggles 1, 0, 1 with out_ready = 1. out_valid follows the same 1, 0, 1 pattern delayed by 2 cycles, with correct data.
